// File: rtl/dmem_bridge.sv
// Load/store bridge from the core data port onto a registered req/ack word bus, with byte lanes, load extension and an ack timeout.
// Latency: with an immediate ack, stall is high for 2 cycles and data is valid in the 3rd. A withheld bus_ack keeps the core stalled for at most TIMEOUT REQ cycles.
module dmem_bridge #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    input  logic              core_we,
    input  logic              core_re,
    input  logic [2:0]        core_funct3,
    output logic [31:0]       core_rdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_off;
    logic [2:0]         r_funct3;
    logic               r_req;
    logic               r_we;
    logic               r_misalign;
    logic               r_err;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;

    logic               w_access;
    logic               w_aligned;
    logic               w_cnt_last;
    logic               w_stall;
    logic [1:0]         w_off;
    logic [3:0]         w_be;
    logic [31:0]        w_shift;
    logic [31:0]        w_ext;
    logic               w_unused_addr;

    assign w_off         = core_addr[1:0];
    assign w_access      = core_we | core_re;
    assign w_cnt_last    = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_unused_addr = ^core_addr[31:ADDR_W+2];

    // funct3[1:0] selects the size; 011/110/111 fall into the word case
    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        case (core_funct3[1:0])
            2'b00: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << w_off;
            end
            2'b01: begin
                w_aligned = ~w_off[0];
                w_be      = 4'b0011 << w_off;
            end
            default: begin
                w_aligned = (w_off == 2'b00);
                w_be      = 4'b1111;
            end
        endcase
    end

    assign w_shift = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = bus_rdata;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_ext = {24'd0, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = bus_rdata;
        endcase
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && w_aligned) begin
                    w_stall = 1'b1;
                    w_next  = REQ;
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (bus_ack || w_cnt_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt      <= '0;
            r_off      <= 2'd0;
            r_funct3   <= 3'd0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            r_req    <= 1'b1;
                            r_we     <= core_we;
                            r_addr   <= core_addr[ADDR_W+1:2];
                            r_be     <= w_be;
                            r_wdata  <= core_wdata << {w_off, 3'b000};
                            r_off    <= w_off;
                            r_funct3 <= core_funct3;
                            r_cnt    <= '0;
                        end else begin
                            r_misalign <= 1'b1;
                            r_rdata    <= 32'd0;
                        end
                    end
                end
                REQ: begin
                    // an ack on the last counted cycle still wins over the timeout
                    if (bus_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_ext;
                        end
                    end else if (w_cnt_last) begin
                        r_req   <= 1'b0;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall      = w_stall;
    assign core_rdata = r_rdata;
    assign misalign   = r_misalign;
    assign bus_err    = r_err;
    assign bus_req    = r_req;
    assign bus_we     = r_we;
    assign bus_addr   = r_addr;
    assign bus_be     = r_be;
    assign bus_wdata  = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: transaction-level timeline model checked every cycle, plus directed literal checks.
module tb_dmem_bridge;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              CLK;
    logic              RST;
    logic [31:0]       core_addr;
    logic [31:0]       core_wdata;
    logic              core_we;
    logic              core_re;
    logic [2:0]        core_funct3;
    logic [31:0]       core_rdata;
    logic              stall;
    logic              misalign;
    logic              bus_err;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    dmem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
        .core_re(core_re), .core_funct3(core_funct3), .core_rdata(core_rdata),
        .stall(stall), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // expected outputs for the current cycle
    logic              exp_stall = 1'b0;
    logic              exp_req   = 1'b0;
    logic              exp_we    = 1'b0;
    logic [ADDR_W-1:0] exp_addr  = '0;
    logic [3:0]        exp_be    = 4'd0;
    logic [31:0]       exp_wdata = 32'd0;
    logic              exp_mis   = 1'b0;
    logic              exp_err   = 1'b0;
    logic [31:0]       exp_rdata = 32'd0;

    // observations over the most recent access
    int          obs_stall_cnt;
    int          obs_req_cnt;
    int          obs_mis_cnt;
    logic        obs_req_seen;
    logic [31:0] obs_rdata;
    logic [31:0] obs_err;
    logic [31:0] obs_be;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;
    logic [31:0] obs_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("stall",      32'(stall),      32'(exp_stall));
            chk("bus_req",    32'(bus_req),    32'(exp_req));
            chk("bus_we",     32'(bus_we),     32'(exp_we));
            chk("bus_addr",   32'(bus_addr),   32'(exp_addr));
            chk("bus_be",     32'(bus_be),     32'(exp_be));
            chk("bus_wdata",  bus_wdata,       exp_wdata);
            chk("misalign",   32'(misalign),   32'(exp_mis));
            chk("bus_err",    32'(bus_err),    32'(exp_err));
            chk("core_rdata", core_rdata,      exp_rdata);
        end
    end

    task automatic next_cycle();
        #2;
        obs_stall_cnt += int'(stall);
        obs_req_cnt   += int'(bus_req);
        obs_mis_cnt   += int'(misalign);
        obs_rdata = core_rdata;
        obs_err   = 32'(bus_err);
        if (bus_req && !obs_req_seen) begin
            obs_req_seen = 1'b1;
            obs_be    = 32'(bus_be);
            obs_wdata = bus_wdata;
            obs_addr  = 32'(bus_addr);
            obs_we    = 32'(bus_we);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        core_we     = 1'b0;
        core_re     = 1'b0;
        core_addr   = $urandom;
        core_wdata  = $urandom;
        core_funct3 = 3'($urandom_range(0, 7));
        bus_ack     = 1'($urandom_range(0, 1));
        bus_rdata   = $urandom;
    endtask

    task automatic idle_cycle();
        drive_idle();
        exp_stall = 1'b0;
        exp_mis   = 1'b0;
        exp_err   = 1'b0;
        next_cycle();
    endtask

    // d = REQ cycles before bus_ack (0 = first REQ cycle); d >= TIMEOUT withholds ack
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic re, input logic [2:0] f3, input int d,
                          input logic [31:0] rd);
        int   off;
        int   sz;
        int   nreq;
        logic tmo;
        logic [31:0] w;
        logic [31:0] v;
        obs_stall_cnt = 0;
        obs_req_cnt   = 0;
        obs_mis_cnt   = 0;
        obs_req_seen  = 1'b0;
        obs_be = 0; obs_wdata = 0; obs_addr = 0; obs_we = 0;
        off = int'(a[1:0]);
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        core_addr   = a;
        core_wdata  = wd;
        core_we     = we;
        core_re     = re;
        core_funct3 = f3;
        bus_ack     = 1'($urandom_range(0, 1));
        bus_rdata   = $urandom;
        exp_mis = 1'b0;
        exp_err = 1'b0;
        if ((off % sz) != 0) begin
            exp_stall = 1'b0;
            next_cycle();
            drive_idle();
            exp_mis   = 1'b1;
            exp_rdata = 32'd0;
            next_cycle();
            exp_mis = 1'b0;
            return;
        end
        exp_stall = 1'b1;
        next_cycle();
        exp_req   = 1'b1;
        exp_we    = we;
        exp_addr  = a[ADDR_W+1:2];
        exp_be    = 4'(((32'd1 << sz) - 32'd1) << off);
        exp_wdata = wd << (8 * off);
        tmo  = (d >= TIMEOUT);
        nreq = tmo ? TIMEOUT : d + 1;
        for (int i = 0; i < nreq; i++) begin
            bus_ack   = !tmo && (i == d);
            bus_rdata = bus_ack ? rd : $urandom;
            next_cycle();
        end
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        if (tmo) begin
            exp_err   = 1'b1;
            exp_rdata = 32'd0;
        end else if (!we) begin
            w = rd >> (8 * off);
            if (sz == 1) begin
                v = w & 32'hFF;
                if (!f3[2] && v >= 32'd128) v = v - 32'd256;
            end else if (sz == 2) begin
                v = w & 32'hFFFF;
                if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
            end else begin
                v = rd;
            end
            exp_rdata = v;
        end
        next_cycle();
        exp_err = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        int op;
        int r;
        int dly;
        RST = 1'b0;
        core_addr = 0; core_wdata = 0; core_we = 0; core_re = 0; core_funct3 = 0;
        bus_ack = 0; bus_rdata = 0;
        #1 RST = 1'b1;
        #2;
        chk("rst_bus_req",   32'(bus_req),  0);
        chk("rst_bus_addr",  32'(bus_addr), 0);
        chk("rst_bus_be",    32'(bus_be),   0);
        chk("rst_bus_wdata", bus_wdata,     0);
        chk("rst_rdata",     core_rdata,    0);
        chk("rst_misalign",  32'(misalign), 0);
        chk("rst_bus_err",   32'(bus_err),  0);
        @(posedge CLK);
        #1 RST = 1'b0;
        chk_en = 1'b1;
        idle_cycle();
        idle_cycle();

        access(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 0, 32'hDEADBEEF);
        chk("lw_addr",      obs_addr, 32'd4);
        chk("lw_be",        obs_be, 32'hF);
        chk("lw_stall_cyc", 32'(obs_stall_cnt), 32'd2);
        chk("lw_rdata",     obs_rdata, 32'hDEADBEEF);
        idle_cycle();

        access(32'h13, 32'h0, 1'b0, 1'b1, 3'b000, 0, 32'h80112233);
        chk("lb_be",    obs_be, 32'h8);
        chk("lb_rdata", obs_rdata, 32'hFFFFFF80);
        access(32'h13, 32'h0, 1'b0, 1'b1, 3'b100, 2, 32'h80112233);
        chk("lbu_rdata", obs_rdata, 32'h00000080);

        access(32'h06, 32'h0000ABCD, 1'b1, 1'b0, 3'b001, 1, 32'h55555555);
        chk("sh_we",    obs_we, 32'd1);
        chk("sh_be",    obs_be, 32'hC);
        chk("sh_wdata", obs_wdata, 32'hABCD0000);
        chk("sh_addr",  obs_addr, 32'd1);
        chk("sh_rdata_held", obs_rdata, 32'h00000080);

        access(32'h02, 32'h0, 1'b0, 1'b1, 3'b010, 0, 32'h0);
        chk("mis_req_cyc",   32'(obs_req_cnt), 0);
        chk("mis_pulse_cyc", 32'(obs_mis_cnt), 32'd1);
        chk("mis_stall_cyc", 32'(obs_stall_cnt), 0);

        access(32'h40, 32'h0, 1'b0, 1'b1, 3'b010, 100, 32'h0);
        chk("tmo_req_cyc", 32'(obs_req_cnt), 32'd16);
        chk("tmo_err",     obs_err, 32'd1);
        chk("tmo_rdata",   obs_rdata, 0);

        access(32'h44, 32'h0, 1'b0, 1'b1, 3'b010, TIMEOUT - 1, 32'h13579BDF);
        chk("lastack_err",   obs_err, 0);
        chk("lastack_rdata", obs_rdata, 32'h13579BDF);
        chk("lastack_req",   32'(obs_req_cnt), 32'd16);

        // reset in the middle of REQ
        core_addr = 32'h20; core_wdata = 32'h12345678; core_we = 1'b0; core_re = 1'b1;
        core_funct3 = 3'b010; bus_ack = 1'b0;
        exp_stall = 1'b1;
        next_cycle();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 10'd8; exp_be = 4'hF; exp_wdata = 32'h12345678;
        #1;
        chk_en = 1'b0;
        drive_idle();
        bus_ack = 1'b0;
        RST = 1'b1;
        #1;
        chk("arst_bus_req",   32'(bus_req),  0);
        chk("arst_stall",     32'(stall),    0);
        chk("arst_bus_addr",  32'(bus_addr), 0);
        chk("arst_bus_be",    32'(bus_be),   0);
        chk("arst_bus_wdata", bus_wdata,     0);
        chk("arst_rdata",     core_rdata,    0);
        @(posedge CLK);
        #1 RST = 1'b0;
        exp_stall = 0; exp_req = 0; exp_we = 0; exp_addr = '0; exp_be = 0;
        exp_wdata = 0; exp_mis = 0; exp_err = 0; exp_rdata = 0;
        chk_en = 1'b1;
        idle_cycle();
        access(32'h24, 32'h0, 1'b0, 1'b1, 3'b010, 1, 32'hCAFEF00D);
        chk("post_rst_rdata", obs_rdata, 32'hCAFEF00D);

        for (int k = 0; k < 250; k++) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            ra  = $urandom;
            op  = $urandom_range(0, 2);
            r   = $urandom_range(0, 19);
            dly = (r < 15) ? (r % 4) : (r < 17) ? TIMEOUT - 1 : (r < 18) ? TIMEOUT - 2 : 40;
            access(ra, $urandom, op != 0, op != 1, 3'($urandom_range(0, 7)), dly, $urandom);
        end
        idle_cycle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Load/store bridge between the single-cycle CPU core and a word-wide data-memory/peripheral bus that uses a req/ack handshake.
- Consumes the core's data address, store data and read/write strobes plus the funct3 field.
- Generates byte enables and shifted store data, and performs the bus transaction.
- Stalls the core until the access completes, then returns sign/zero-extended load data.

Parameters:
ADDR_W, 10, word-address width on the bus side (bus_addr = core_addr[ADDR_W+1:2])
TIMEOUT, 16, cycles spent in REQ without bus_ack before the access aborts with bus_err

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
core_addr  in  32  byte address from the ALU result
core_wdata  in  32  store data (rs2)
core_we  in  1  store request (MemWrite)
core_re  in  1  load request (MemRead)
core_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
core_rdata  out  32  extended load data, valid in DONE
stall  out  1  holds the core's PC and register write
misalign  out  1  one-cycle pulse on a misaligned access
bus_err  out  1  one-cycle pulse, in DONE, on a timeout
bus_req  out  1  bus request, registered
bus_we  out  1  bus write, registered
bus_addr  out  ADDR_W  word address, registered
bus_be  out  4  byte enables, registered
bus_wdata  out  32  lane-shifted store data, registered
bus_ack  in  1  bus completion; bus_rdata is valid in the same cycle
bus_rdata  in  32  bus read word

Behaviour:
- Reset: state=IDLE. All of the following are 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, core_rdata, misalign, bus_err, and the timeout counter. Because reset is asynchronous, an access in flight is abandoned and bus_req drops immediately.
- Access = core_we | core_re. If both are high, the access is a write.
- Offset off = core_addr[1:0].
- Alignment: H/HU requires off[0]=0; W requires off=0. Funct3 codes 011, 110 and 111 are treated as W.
- Registered outputs (misalign, bus_req/we/addr/be/wdata, bus_err, core_rdata) change on the CLK edge after the condition that sets them.
- FSM states are IDLE, REQ and DONE.
- IDLE, aligned access:
  - stall=1 combinationally.
  - Latch bus_addr, bus_we, off, funct3.
  - bus_be: B = 0001<<off; H = 0011<<off; W = 1111.
  - bus_wdata = core_wdata<<(8*off).
  - Clear the timeout counter and go to REQ.
- IDLE, misaligned access:
  - No bus cycle and stall=0.
  - misalign=1 for the following cycle; core_rdata=0.
  - State stays IDLE.
- IDLE with no access: stall=0. bus_ack is ignored.
- REQ:
  - bus_req=1 and stall=1.
  - On bus_ack: capture the extended bus_rdata (loads only), drop bus_req, go to DONE.
  - Otherwise the counter increments. When counter = TIMEOUT-1 with no ack: drop bus_req, set core_rdata=0, and raise bus_err during DONE.
- DONE:
  - stall=0, so the core retires the instruction this cycle.
  - core_rdata is valid for the whole state.
  - Always go to IDLE next cycle. An access presented in DONE is not sampled.
- Load extension on byte = bus_rdata[8*off+:8] and half = bus_rdata[8*off+:16]:
  - B: sign-extend byte.
  - BU: zero-extend byte.
  - H: sign-extend half.
  - HU: zero-extend half.
  - W: whole word.
- core_rdata holds its last value until the next completed load. Stores do not update it.
- Latency: with ack in the first REQ cycle, stall is high for 2 cycles and data is valid in the 3rd.
- A bus_ack that arrives in the same cycle the counter reaches TIMEOUT-1 is a success, not a timeout.

Test Plan:
- LW addr 0x10, ack in first REQ cycle, bus_rdata=0xDEADBEEF -> bus_addr=4, bus_be=1111, stall high 2 cycles, core_rdata=0xDEADBEEF in DONE.
- LB addr 0x13, bus_rdata=0x80112233 -> bus_be=1000, core_rdata=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr 0x06, wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCD0000, bus_addr=1.
- LW addr 0x02 -> no bus_req, misalign=1 one cycle, stall never asserted.
- LW with bus_ack withheld and TIMEOUT=16 -> bus_req high exactly 16 cycles, bus_err=1 in DONE, core_rdata=0.
- RST asserted during REQ -> bus_req=0 immediately, state IDLE, all outputs 0, next LW completes normally.
